sort_ctrl: RTL

Sequencing controller that drives the shared 2-bit-opcode ALU from the initiator side: it issues CMP and PLUS operations and consumes `out0`/`zero`/`bigger`. It owns an N-entry word buffer, sorts it ascending (unsigned) by bubble sort with early exit, then sums it through the ALU. It sits between the board-level host logic (switches, display) and the combinational ALU.

---
 rtl/sort_ctrl_if.sv | 31 +++
 rtl/sort_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/sort_ctrl_if.sv
// Host and ALU signal bundle for sort_ctrl.
// The slave modport is the controller's view; the master modport is the host plus ALU side.
interface sort_ctrl_if #(
    parameter int unsigned W = 32
);
    logic         we;
    logic [3:0]   addr;
    logic [W-1:0] din;
    logic [W-1:0] rdout;
    logic         start;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic [15:0]  swaps;
    logic [W-1:0] alu_in0;
    logic [W-1:0] alu_in1;
    logic [1:0]   alu_op;
    logic [W-1:0] alu_out;
    logic         alu_zero;
    logic         alu_bigger;

    modport master (
        output we, addr, din, start, alu_out, alu_zero, alu_bigger,
        input  rdout, busy, done, sum, swaps, alu_in0, alu_in1, alu_op
    );

    modport slave (
        input  we, addr, din, start, alu_out, alu_zero, alu_bigger,
        output rdout, busy, done, sum, swaps, alu_in0, alu_in1, alu_op
    );
endinterface

// File: rtl/sort_ctrl.sv
// Owns an N-word buffer and bubble-sorts it ascending (with early exit), then sums it,
// issuing every compare and add through an external combinational ALU.
module sort_ctrl #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 32
) (
    input  logic       clk,
    input  logic       rstn,
    sort_ctrl_if.slave bus
);
    localparam int unsigned AW = $clog2(N);
    localparam int unsigned CW = 5;
    localparam int unsigned SW = 16;

    localparam logic [1:0] OP_NOP  = 2'd0;
    localparam logic [1:0] OP_CMP  = 2'd1;
    localparam logic [1:0] OP_PLUS = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMP,
        S_SWAP,
        S_SUM,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  mem_q [N];
    logic [W-1:0]  mem_d [N];
    logic [AW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
    logic          swapped_q, swapped_d;
    logic [SW-1:0] swaps_q, swaps_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  sum_q, sum_d;

    logic          adv_c;
    logic          swapped_c;
    logic          addr_ok_c;
    logic [AW-1:0] j_nx_c;

    assign addr_ok_c = CW'(bus.addr) < CW'(N);
    assign j_nx_c    = j_q + AW'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            mem_q     <= '{default: '0};
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            swapped_q <= 1'b0;
            swaps_q   <= '0;
            acc_q     <= '0;
            sum_q     <= '0;
        end else begin
            state_q   <= state_d;
            mem_q     <= mem_d;
            i_q       <= i_d;
            j_q       <= j_d;
            k_q       <= k_d;
            swapped_q <= swapped_d;
            swaps_q   <= swaps_d;
            acc_q     <= acc_d;
            sum_q     <= sum_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_d       = mem_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        swapped_d   = swapped_q;
        swaps_d     = swaps_q;
        acc_d       = acc_q;
        sum_d       = sum_q;
        adv_c       = 1'b0;
        swapped_c   = swapped_q;
        bus.alu_op  = OP_NOP;
        bus.alu_in0 = '0;
        bus.alu_in1 = '0;

        case (state_q)
            S_IDLE: begin
                // A write in the start cycle lands before the sort reads the buffer.
                if (bus.we && addr_ok_c) begin
                    mem_d[AW'(bus.addr)] = bus.din;
                end
                if (bus.start) begin
                    i_d       = '0;
                    j_d       = '0;
                    k_d       = '0;
                    swapped_d = 1'b0;
                    swaps_d   = '0;
                    acc_d     = '0;
                    state_d   = S_CMP;
                end
            end
            S_CMP: begin
                bus.alu_op  = OP_CMP;
                bus.alu_in0 = mem_q[j_q];
                bus.alu_in1 = mem_q[j_nx_c];
                if (bus.alu_bigger && !bus.alu_zero) begin
                    state_d = S_SWAP;
                end else begin
                    adv_c = 1'b1;
                end
            end
            S_SWAP: begin
                mem_d[j_q]    = mem_q[j_nx_c];
                mem_d[j_nx_c] = mem_q[j_q];
                swapped_d     = 1'b1;
                swapped_c     = 1'b1;
                swaps_d       = swaps_q + SW'(1);
                adv_c         = 1'b1;
            end
            S_SUM: begin
                bus.alu_op  = OP_PLUS;
                bus.alu_in0 = acc_q;
                bus.alu_in1 = mem_q[k_q];
                acc_d       = bus.alu_out;
                k_d         = k_q + AW'(1);
                if (k_q == AW'(N - 1)) begin
                    sum_d   = bus.alu_out;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Step to the next pair; j+i < N-2 avoids underflow of N-2-i.
        if (adv_c) begin
            if ((CW'(j_q) + CW'(i_q)) < CW'(N - 2)) begin
                j_d     = j_nx_c;
                state_d = S_CMP;
            end else if (!swapped_c || (i_q == AW'(N - 2))) begin
                k_d     = '0;
                state_d = S_SUM;
            end else begin
                i_d       = i_q + AW'(1);
                j_d       = '0;
                swapped_d = 1'b0;
                state_d   = S_CMP;
            end
        end
    end

    assign bus.rdout = addr_ok_c ? mem_q[AW'(bus.addr)] : '0;
    assign bus.busy  = (state_q == S_CMP) || (state_q == S_SWAP) || (state_q == S_SUM);
    assign bus.done  = (state_q == S_DONE);
    assign bus.sum   = sum_q;
    assign bus.swaps = swaps_q;
endmodule
